// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared register indices and memory FSM state type for reg_bank_param
package reg_bank_pkg;

  localparam int REG_PC  = 0;
  localparam int REG_MDR = 1;
  localparam int REG_MAR = 2;
  localparam int REG_IR  = 3;
  localparam int REG_GP0 = 4;

  localparam int INC_PC  = 0;
  localparam int INC_MAR = 1;
  localparam int INC_MDR = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/reg_bank_mem_fsm.sv
// rtl/reg_bank_mem_fsm.sv - req/ack data-memory handshake FSM owning MDR capture
module reg_bank_mem_fsm
  import reg_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic dmem_ack,
  output logic busy,
  output logic dmem_req,
  output logic dmem_we,
  output logic mdr_capture
);

  mem_state_t state_q;
  mem_state_t state_d;

  // Requests are only accepted from IDLE; read takes precedence over write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_rd)      state_d = ST_RD_WAIT;
        else if (mem_wr) state_d = ST_WR_WAIT;
      end
      ST_RD_WAIT: if (dmem_ack) state_d = ST_IDLE;
      ST_WR_WAIT: if (dmem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign busy        = (state_q != ST_IDLE);
  assign dmem_req    = busy;
  assign dmem_we     = (state_q == ST_WR_WAIT);
  assign mdr_capture = (state_q == ST_RD_WAIT) && dmem_ack;

endmodule

// File: rtl/reg_bank_param.sv
// rtl/reg_bank_param.sv - parametrised PC/IR/MDR/MAR/AC/GP register bank with A/B/C buses
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int INS_ADDR_W = 8,
  parameter int NUM_GP     = 2,
  parameter int SEL_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     c_bus,
  output logic [DATA_W-1:0]     a_bus,
  output logic [DATA_W-1:0]     b_bus,
  input  logic [SEL_W-1:0]      b_sel,
  input  logic [4+NUM_GP-1:0]   ld_en,
  input  logic                  ld_ac,
  input  logic [2:0]            inc_en,
  input  logic                  ir_load,
  output logic [INS_ADDR_W-1:0] ins_addr,
  input  logic [INS_ADDR_W-1:0] ins_data,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  output logic                  busy,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  input  logic                  z_update,
  output logic                  z_flag
);

  localparam int NUM_SRC = 4 + NUM_GP;

  logic [INS_ADDR_W-1:0] pc_q;
  logic [INS_ADDR_W-1:0] ir_q;
  logic [DATA_W-1:0]     mdr_q;
  logic [DATA_W-1:0]     mar_q;
  logic [DATA_W-1:0]     ac_q;
  logic                  z_q;
  logic                  mdr_capture;

  logic [NUM_SRC-1:0][DATA_W-1:0] b_src;

  // IR has no C-bus path; its ld_en bit exists only to keep indices aligned with b_sel.
  logic unused_ir_ld;
  assign unused_ir_ld = ld_en[REG_IR];

  reg_bank_mem_fsm u_mem_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .dmem_ack    (dmem_ack),
    .busy        (busy),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .mdr_capture (mdr_capture)
  );

  always_ff @(posedge clk) begin
    if (rst)                   pc_q <= '0;
    else if (ld_en[REG_PC])    pc_q <= c_bus[INS_ADDR_W-1:0];
    else if (inc_en[INC_PC])   pc_q <= pc_q + INS_ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          ir_q <= '0;
    else if (ir_load) ir_q <= ins_data;
  end

  // MAR and MDR are frozen while a memory transaction is outstanding so the
  // address and write data presented to memory stay stable.
  always_ff @(posedge clk) begin
    if (rst)                            mar_q <= '0;
    else if (!busy && ld_en[REG_MAR])   mar_q <= c_bus;
    else if (!busy && inc_en[INC_MAR])  mar_q <= mar_q + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                            mdr_q <= '0;
    else if (mdr_capture)               mdr_q <= dmem_rdata;
    else if (!busy && ld_en[REG_MDR])   mdr_q <= c_bus;
    else if (!busy && inc_en[INC_MDR])  mdr_q <= mdr_q + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)        ac_q <= '0;
    else if (ld_ac) ac_q <= c_bus;
  end

  // Z samples the pre-edge AC, so a same-edge ld_ac does not affect it.
  always_ff @(posedge clk) begin
    if (rst)           z_q <= 1'b0;
    else if (z_update) z_q <= (ac_q == '0);
  end

  assign b_src[REG_PC]  = DATA_W'(pc_q);
  assign b_src[REG_MDR] = mdr_q;
  assign b_src[REG_MAR] = mar_q;
  assign b_src[REG_IR]  = DATA_W'(ir_q);

  for (genvar g = 0; g < NUM_GP; g++) begin : gen_gp
    logic [DATA_W-1:0] gp_q;

    always_ff @(posedge clk) begin
      if (rst)                    gp_q <= '0;
      else if (ld_en[REG_GP0+g])  gp_q <= c_bus;
    end

    assign b_src[REG_GP0+g] = gp_q;
  end

  always_comb begin
    b_bus = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (b_sel == SEL_W'(i)) b_bus = b_src[i];
    end
  end

  assign a_bus      = ac_q;
  assign ins_addr   = pc_q;
  assign dmem_addr  = mar_q;
  assign dmem_wdata = mdr_q;
  assign z_flag     = z_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// tb/tb_reg_bank_param.sv - directed self-checking bench for reg_bank_param
module tb_reg_bank_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] c_bus;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [3:0]  b_sel;
  logic [5:0]  ld_en;
  logic        ld_ac;
  logic [2:0]  inc_en;
  logic        ir_load;
  logic [7:0]  ins_addr;
  logic [7:0]  ins_data;
  logic        mem_rd;
  logic        mem_wr;
  logic        busy;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic        z_update;
  logic        z_flag;

  int vectors = 0;
  int miscompares = 0;

  reg_bank_param #(
    .DATA_W(16), .INS_ADDR_W(8), .NUM_GP(2), .SEL_W(4)
  ) dut (
    .clk(clk), .rst(rst), .c_bus(c_bus), .a_bus(a_bus), .b_bus(b_bus),
    .b_sel(b_sel), .ld_en(ld_en), .ld_ac(ld_ac), .inc_en(inc_en),
    .ir_load(ir_load), .ins_addr(ins_addr), .ins_data(ins_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .z_update(z_update),
    .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic peek_b(input logic [3:0] sel, input string tag, input logic [15:0] exp);
    b_sel = sel;
    #1;
    check(tag, 32'(b_bus), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; c_bus = '0; b_sel = '0; ld_en = '0; ld_ac = 1'b0; inc_en = '0;
    ir_load = 1'b0; ins_data = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0; z_update = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_a_bus", 32'(a_bus), 0);
    check("rst_ins_addr", 32'(ins_addr), 0);
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(dmem_addr), 0);
    check("rst_wdata", 32'(dmem_wdata), 0);
    check("rst_z", 32'(z_flag), 0);
    for (int i = 0; i < 6; i++) peek_b(4'(i), "rst_b_bus", 16'h0000);

    // GP0 load via C bus
    c_bus = 16'h1234; ld_en = 6'b01_0000;
    tick();
    ld_en = '0;
    peek_b(4'd4, "gp0_load", 16'h1234);
    peek_b(4'd5, "gp1_untouched", 16'h0000);
    peek_b(4'd15, "b_sel_out_of_range", 16'h0000);

    // PC load beats increment
    c_bus = 16'h0010; ld_en = 6'b00_0001; inc_en = 3'b001;
    tick();
    ld_en = '0; inc_en = '0;
    check("pc_load_wins", 32'(ins_addr), 32'h10);
    peek_b(4'd0, "pc_on_b", 16'h0010);

    // PC wrap
    c_bus = 16'h00FF; ld_en = 6'b00_0001;
    tick();
    ld_en = '0; inc_en = 3'b001;
    tick();
    inc_en = '0;
    check("pc_wrap", 32'(ins_addr), 32'h00);

    // IR zero-extended onto B bus
    ins_data = 8'hA5; ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    peek_b(4'd3, "ir_zext", 16'h00A5);

    // Read handshake, ack after 3 request cycles
    c_bus = 16'h0040; ld_en = 6'b00_0100;
    tick();
    ld_en = '0;
    check("mar_load", 32'(dmem_addr), 32'h40);
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0; inc_en = 3'b010;
    check("rd_req_c1", 32'(dmem_req), 1);
    check("rd_we_c1", 32'(dmem_we), 0);
    check("rd_busy_c1", 32'(busy), 1);
    check("rd_addr_c1", 32'(dmem_addr), 32'h40);
    tick();
    check("rd_req_c2", 32'(dmem_req), 1);
    check("rd_addr_c2", 32'(dmem_addr), 32'h40);
    tick();
    check("rd_req_c3", 32'(dmem_req), 1);
    check("rd_addr_c3", 32'(dmem_addr), 32'h40);
    dmem_ack = 1'b1; dmem_rdata = 16'hBEEF; mem_rd = 1'b1;
    tick();
    dmem_ack = 1'b0; mem_rd = 1'b0; inc_en = '0;
    check("rd_req_done", 32'(dmem_req), 0);
    check("rd_busy_done", 32'(busy), 0);
    check("rd_mdr", 32'(dmem_wdata), 32'hBEEF);
    check("rd_mar_inc_ignored", 32'(dmem_addr), 32'h40);
    peek_b(4'd1, "rd_mdr_on_b", 16'hBEEF);

    // Ack while idle does nothing
    dmem_ack = 1'b1; dmem_rdata = 16'h1111;
    tick();
    dmem_ack = 1'b0;
    check("idle_ack_mdr", 32'(dmem_wdata), 32'hBEEF);
    check("idle_ack_req", 32'(dmem_req), 0);

    // Write handshake, ack in first cycle; mem_wr during busy dropped
    c_bus = 16'h00AA; ld_en = 6'b00_0010;
    tick();
    ld_en = '0;
    check("mdr_load", 32'(dmem_wdata), 32'hAA);
    mem_wr = 1'b1;
    tick();
    check("wr_req", 32'(dmem_req), 1);
    check("wr_we", 32'(dmem_we), 1);
    check("wr_wdata", 32'(dmem_wdata), 32'hAA);
    dmem_ack = 1'b1; dmem_rdata = 16'h5555; inc_en = 3'b100;
    tick();
    mem_wr = 1'b0; dmem_ack = 1'b0; inc_en = '0;
    check("wr_done_req", 32'(dmem_req), 0);
    check("wr_done_we", 32'(dmem_we), 0);
    check("wr_done_busy", 32'(busy), 0);
    check("wr_no_capture", 32'(dmem_wdata), 32'hAA);
    tick();
    check("wr_dropped_idle", 32'(dmem_req), 0);

    // MAR/MDR increment when idle
    inc_en = 3'b110;
    tick();
    inc_en = '0;
    check("mar_inc_idle", 32'(dmem_addr), 32'h41);
    check("mdr_inc_idle", 32'(dmem_wdata), 32'hAB);

    // Simultaneous rd+wr -> read
    mem_rd = 1'b1; mem_wr = 1'b1;
    tick();
    mem_rd = 1'b0; mem_wr = 1'b0;
    check("sim_req", 32'(dmem_req), 1);
    check("sim_is_read", 32'(dmem_we), 0);

    // Reset with ack in RD_WAIT aborts without capture
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'h7777;
    tick();
    rst = 1'b0; dmem_ack = 1'b0;
    check("abort_req", 32'(dmem_req), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_mdr", 32'(dmem_wdata), 0);
    tick();
    check("abort_stays_idle", 32'(dmem_req), 0);

    // Z flag
    z_update = 1'b1;
    tick();
    check("z_ac_zero", 32'(z_flag), 1);
    c_bus = 16'h0005; ld_ac = 1'b1;
    tick();
    ld_ac = 1'b0;
    check("z_old_ac", 32'(z_flag), 1);
    check("ac_loaded", 32'(a_bus), 32'h5);
    tick();
    z_update = 1'b0;
    check("z_ac_nonzero", 32'(z_flag), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
# reg_bank_param

Parametrised processor register bank for the image-processing datapath. It holds PC, IR, MDR, MAR, AC and a configurable number of general-purpose registers. AC drives the A bus; the C bus writes the registers, and any register can be selected onto the B bus. It adds a req/ack data-memory handshake (MDR load/store owned by a small FSM), registered auto-increment, and a Z flag, and it sits between the control unit, the ALU and the instruction and data memories.

## Interface
Parameters:
- DATA_W, 16, width of C/A/B buses, MDR, MAR, AC, GP registers
- INS_ADDR_W, 8, PC width / instruction address width (IR width equals INS_ADDR_W)
- NUM_GP, 2, number of general-purpose registers (1..8)
- SEL_W, 4, B-mux select width; must satisfy 2^SEL_W >= 4+NUM_GP

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- c_bus  in  DATA_W  ALU result bus
- a_bus  out  DATA_W  AC contents
- b_bus  out  DATA_W  selected register (combinational)
- b_sel  in  SEL_W  B-bus source: 0 PC, 1 MDR, 2 MAR, 3 IR, 4+k GPk; out of range gives 0
- ld_en  in  4+NUM_GP  per-register C-bus load, same index as b_sel (bit 3, IR, unused)
- ld_ac  in  1  load AC from c_bus
- inc_en  in  3  bit0 PC+1, bit1 MAR+1, bit2 MDR+1
- ir_load  in  1  load IR from ins_data
- ins_addr  out  INS_ADDR_W  equals PC
- ins_data  in  INS_ADDR_W  instruction memory data
- mem_rd, mem_wr  in  1  start a data-memory read/write (pulses)
- busy  out  1  memory FSM not IDLE
- dmem_req  out  1  memory request
- dmem_we  out  1  1 for write, 0 for read; valid while dmem_req is high
- dmem_addr  out  DATA_W  equals MAR
- dmem_wdata  out  DATA_W  equals MDR
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- dmem_ack  in  1  completes the current request
- z_update  in  1  refresh Z flag
- z_flag  out  1  AC==0 as of the last update

## Operation
- Reset: all registers, z_flag, dmem_req, dmem_we and busy are 0; FSM is IDLE.
- Register update priority per register, highest first:
  - memory capture (MDR only)
  - C-bus load
  - increment
  - hold
- Increments wrap modulo 2^width. For example, PC 0xFF+1 becomes 0x00 with INS_ADDR_W=8.
- IR is zero-extended to DATA_W on the B bus.
- Memory FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE with mem_rd: go to RD_WAIT.
  - IDLE with mem_wr: go to WR_WAIT.
  - IDLE with mem_rd and mem_wr together: read wins and the write is dropped.
  - RD_WAIT/WR_WAIT: dmem_req is 1. dmem_we is 0 in RD_WAIT and 1 in WR_WAIT.
  - RD_WAIT with dmem_ack: MDR captures dmem_rdata and the FSM returns to IDLE.
  - WR_WAIT with dmem_ack: the FSM returns to IDLE.
- While busy:
  - mem_rd and mem_wr are ignored, not queued.
  - MAR ld_en and inc_en are ignored.
  - MDR ld_en and inc_en are ignored, so dmem_addr and dmem_wdata stay stable.
- Asserting rst during RD_WAIT or WR_WAIT aborts the request. dmem_req is 0 after that edge and MDR is cleared, not captured, even if dmem_ack is high on the same edge.
- z_update sets z_flag to (AC == 0), using AC before the edge. If ld_ac and z_update fall on the same edge, the flag reflects the old AC.

## Timing
- Every register updates on the rising clk edge. b_bus, a_bus, ins_addr, dmem_addr, dmem_wdata and busy are combinational from registered state.
- Read sequence:
  - mem_rd is sampled at edge N; dmem_req is high from N.
  - dmem_ack is sampled at edge M > N; MDR holds dmem_rdata from M, and dmem_req and busy are low from M.
  - Minimum latency is 1 cycle (ack in the first request cycle).
  - With no ack, dmem_req stays high indefinitely; there is no timeout.
- dmem_ack seen while IDLE is ignored.
- A new mem_rd presented at edge M, the same edge as the ack, is ignored because the FSM was busy at that edge. A new request is accepted from edge M+1.

## Structure
- A shared package reg_bank_pkg holds:
  - register index constants REG_PC=0, REG_MDR=1, REG_MAR=2, REG_IR=3, REG_GP0=4
  - the memory FSM state enum (IDLE, RD_WAIT, WR_WAIT)
- One sub-module, reg_bank_mem_fsm, contains the handshake FSM. It outputs busy, dmem_req, dmem_we and the MDR capture strobe.
- The register array and the B mux are built with a generate loop over NUM_GP.

## Test plan
- Reset then idle: all outputs are 0; b_sel=0..5 gives b_bus=0; z_flag=0.
- Load/select: c_bus=0x1234 with ld_en bit 4 -> b_sel=4 gives 0x1234. ld_en[0] and inc_en[0] together with c_bus=0x0010 -> PC=0x10, the load wins. PC=0xFF with inc -> PC=0x00.
- Read handshake: MAR=0x0040, pulse mem_rd, ack 3 cycles later with rdata=0xBEEF:
  - dmem_req is high for exactly 3 cycles with dmem_addr=0x0040 throughout.
  - MDR=0xBEEF afterwards.
  - A MAR inc during busy is ignored.
- Write handshake: MDR=0x00AA, pulse mem_wr, ack in the first cycle -> dmem_we=1 and wdata=0x00AA for 1 cycle, then IDLE. A mem_wr during busy is dropped.
- Simultaneous and abort cases:
  - mem_rd and mem_wr together -> read only.
  - rst with ack in RD_WAIT -> MDR=0, dmem_req=0, FSM IDLE.
- Z flag: AC=0 with z_update -> z_flag=1. ld_ac c_bus=5 with z_update on the same edge -> z_flag stays 1; the next z_update gives 0.
